transpose_ctrl: RTL
===================

TRANSPOSE_CTRL -- requirements
Module: transpose_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16, element width in bits; TILE_LINES = 512/DATA_WIDTH (32 at default); AW = log2(TILE_LINES) (5 at default).
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 start  input  1  one-cycle pulse; begins a context.
REQ-005 ctx_length  input  32  context size in 512-bit lines; sampled on accepted start.
REQ-006 in_empty  input  1  input FIFO empty.
REQ-007 in_re  output  1  input FIFO read enable; data valid the following cycle.
REQ-008 buf_we  output  1  tile-buffer write enable.
REQ-009 buf_wbank  output  1  tile-buffer write bank (ping-pong).
REQ-010 buf_waddr  output  AW  tile-buffer write row.
REQ-011 buf_re  output  1  tile-buffer read enable; transposed column valid the following cycle.
REQ-012 buf_rbank  output  1  tile-buffer read bank.
REQ-013 buf_raddr  output  AW  tile-buffer read column.
REQ-014 out_almost_full  input  1  output FIFO has at most one free entry.
REQ-015 out_we  output  1  output FIFO write enable.
REQ-016 busy  output  1  context in progress.
REQ-017 done  output  1  one-cycle pulse at context completion.

Function
REQ-018 States: IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE when out_count == tiles*TILE_LINES; DONE->IDLE unconditionally next cycle; busy = (state == RUN); done = (state == DONE).
REQ-019 tiles = ctx_length >> AW; low AW bits ignored; tiles == 0 -> IDLE->DONE->IDLE with no FIFO or buffer activity.
REQ-020 start is ignored in RUN and DONE.
REQ-021 Fill side: in_re = RUN && !in_empty && !bank_full[wbank] && in_count < tiles*TILE_LINES; in_count increments on each in_re.
REQ-022 buf_we is in_re registered by one cycle; buf_waddr increments on each buf_we and wraps TILE_LINES-1 -> 0.
REQ-023 On buf_we with buf_waddr == TILE_LINES-1: set bank_full[wbank] and toggle wbank in the same edge.
REQ-024 Drain side: buf_re = RUN && bank_full[rbank] && !out_almost_full; buf_raddr increments on each buf_re and wraps.
REQ-025 On buf_re with buf_raddr == TILE_LINES-1: clear bank_full[rbank] and toggle rbank in the same edge.
REQ-026 A set of one bank and a clear of the other in the same cycle SHALL both take effect; the set and clear can never target the same bank.
REQ-027 out_we is buf_re registered by one cycle; out_count increments on each out_we.
REQ-028 Fill and drain run concurrently: bank B may fill while bank A drains; steady-state throughput is 1 line per cycle.
REQ-029 No input line is ever read beyond tiles*TILE_LINES, and no out_we is issued after done.
REQ-030 Counters in_count and out_count are 32 bits and are cleared on entry to RUN.

Reset
REQ-031 Reset forces IDLE; in_re, buf_we, buf_re, out_we, busy and done are 0; counters, addresses, wbank, rbank and bank_full are all 0.
REQ-032 Reset mid-context abandons all buffered data with no further FIFO accesses; the next start begins a fresh context.

Verification
REQ-033 ctx_length = 32, FIFO never empty, no backpressure -> 32 in_re, 32 out_we, first out_we 34 cycles after the first in_re, done exactly once.
REQ-034 ctx_length = 128, continuous input -> in_re stays high with no bubble across tile boundaries, bank sequence 0,1,0,1 on both sides, 128 out_we.
REQ-035 out_almost_full held high for 10 cycles mid-drain -> buf_re low for exactly those cycles, no lost or duplicated line, in_re stalls once both banks are full.
REQ-036 ctx_length = 0 and ctx_length = 31 -> done one cycle after start, in_re never asserted.
REQ-037 Reset asserted at line 40 of a 64-line context -> all outputs 0 immediately; a new start with ctx_length = 32 completes normally.
REQ-038 start pulsed during RUN -> ignored, with ctx_length unchanged and the original context completing.

Source files
------------

// File: rtl/transpose_ctrl.sv
// rtl/transpose_ctrl.sv - ping-pong tile transpose sequencer
// Fills one 512-bit tile bank from the input FIFO while the other drains column-wise to the output FIFO.
module transpose_ctrl #(
    parameter int DATA_WIDTH = 16,
    localparam int TILE_LINES = 512 / DATA_WIDTH,
    localparam int AW = $clog2(TILE_LINES)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          start_i,
    input  logic [31:0]   ctx_length_i,
    input  logic          in_empty_i,
    output logic          in_re_o,
    output logic          buf_we_o,
    output logic          buf_wbank_o,
    output logic [AW-1:0] buf_waddr_o,
    output logic          buf_re_o,
    output logic          buf_rbank_o,
    output logic [AW-1:0] buf_raddr_o,
    input  logic          out_almost_full_i,
    output logic          out_we_o,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST_ROW = AW'(TILE_LINES - 1);

    state_t        state_q, state_d;
    logic [31:0]   total_q, total_d;
    logic [31:0]   in_count_q, in_count_d;
    logic [31:0]   out_count_q, out_count_d;
    logic          buf_we_q, buf_we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          wbank_q, wbank_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic          rbank_q, rbank_d;
    logic [1:0]    bank_full_q, bank_full_d;
    logic          out_we_q, out_we_d;

    logic run;
    logic fill_bank;
    logic drain_last;
    logic fill_blocked;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            total_q     <= '0;
            in_count_q  <= '0;
            out_count_q <= '0;
            buf_we_q    <= 1'b0;
            waddr_q     <= '0;
            wbank_q     <= 1'b0;
            raddr_q     <= '0;
            rbank_q     <= 1'b0;
            bank_full_q <= '0;
            out_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
            buf_we_q    <= buf_we_d;
            waddr_q     <= waddr_d;
            wbank_q     <= wbank_d;
            raddr_q     <= raddr_d;
            rbank_q     <= rbank_d;
            bank_full_q <= bank_full_d;
            out_we_q    <= out_we_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        total_d     = total_q;
        in_count_d  = in_count_q;
        out_count_d = out_count_q;
        waddr_d     = waddr_q;
        wbank_d     = wbank_q;
        raddr_d     = raddr_q;
        rbank_d     = rbank_q;
        bank_full_d = bank_full_q;

        run = (state_q == S_RUN);

        // wbank only flips when the previous line lands, so the read is steered by the
        // bank its line will occupy; a bank whose last column is read this cycle counts as free.
        fill_bank    = in_count_q[AW];
        buf_re_o     = run && bank_full_q[rbank_q] && !out_almost_full_i;
        drain_last   = buf_re_o && (raddr_q == LAST_ROW);
        fill_blocked = bank_full_q[fill_bank] && !(drain_last && (rbank_q == fill_bank));
        in_re_o      = run && !in_empty_i && !fill_blocked && (in_count_q < total_q);

        buf_we_d = in_re_o;
        out_we_d = buf_re_o;

        if (in_re_o) begin
            in_count_d = in_count_q + 32'd1;
        end
        if (buf_we_q) begin
            waddr_d = waddr_q + AW'(1);
            if (waddr_q == LAST_ROW) begin
                bank_full_d[wbank_q] = 1'b1;
                wbank_d              = ~wbank_q;
            end
        end
        if (buf_re_o) begin
            raddr_d = raddr_q + AW'(1);
            if (drain_last) begin
                bank_full_d[rbank_q] = 1'b0;
                rbank_d              = ~rbank_q;
            end
        end
        if (out_we_q) begin
            out_count_d = out_count_q + 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    total_d     = ctx_length_i & ~32'(TILE_LINES - 1);
                    in_count_d  = '0;
                    out_count_d = '0;
                    waddr_d     = '0;
                    raddr_d     = '0;
                    wbank_d     = 1'b0;
                    rbank_d     = 1'b0;
                    bank_full_d = '0;
                    state_d     = (ctx_length_i < 32'(TILE_LINES)) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (out_count_q == total_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign buf_we_o    = buf_we_q;
    assign buf_wbank_o = wbank_q;
    assign buf_waddr_o = waddr_q;
    assign buf_rbank_o = rbank_q;
    assign buf_raddr_o = raddr_q;
    assign out_we_o    = out_we_q;
    assign busy_o      = run;
    assign done_o      = (state_q == S_DONE);

endmodule
